dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 17 +
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared core definitions: access-size encodings, responder FSM states and
// the default data-memory base address.
package dmem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data memory: read extraction with sign/zero
// extension, and write-lane mask plus replicated write data.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o
);

  logic [1:0]  lane_eff;
  logic [31:0] shifted;

  always_comb begin
    rdata_o  = '0;
    wmask_o  = '0;
    wdata_o  = '0;
    lane_eff = '0;
    shifted  = '0;
    case (size_i)
      SIZE_BYTE: begin
        lane_eff = lane_i;
        shifted  = mem_word_i >> {lane_eff, 3'b000};
        rdata_o  = {{24{signed_i & shifted[7]}}, shifted[7:0]};
        wmask_o  = 4'b0001 << lane_eff;
        wdata_o  = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        // Odd half addresses are rounded down to the containing half.
        lane_eff = {lane_i[1], 1'b0};
        shifted  = mem_word_i >> {lane_eff, 3'b000};
        rdata_o  = {{16{signed_i & shifted[15]}}, shifted[15:0]};
        wmask_o  = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{wdata_i[15:0]}};
      end
      SIZE_WORD: begin
        rdata_o = mem_word_i;
        wmask_o = '1;
        wdata_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed wait latency.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word into errors.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 262144,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          idle;
  logic          cur_rw, cur_sgn;
  logic [31:0]   cur_addr, cur_wdata;
  logic [1:0]    cur_size;
  logic [31:0]   offset, word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range, access_err, enter_resp, mem_we;
  logic [31:0]   lane_rdata, lane_wdata;
  logic [3:0]    lane_wmask;

  assign idle      = (state_q == ST_IDLE);
  assign req_ready = idle & reset;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero wait the RESP-entry edge is the accept edge, so the access is
  // evaluated from the live request in IDLE and from the latched copy otherwise.
  always_comb begin
    cur_rw    = idle ? req_rw     : rw_q;
    cur_addr  = idle ? req_addr   : addr_q;
    cur_size  = idle ? req_size   : size_q;
    cur_sgn   = idle ? req_signed : sgn_q;
    cur_wdata = idle ? req_wdata  : wdata_q;
  end

  always_comb begin
    offset     = cur_addr - BASE_ADDR;
    word_idx   = offset >> 2;
    mem_idx    = word_idx[AW-1:0];
    in_range   = (cur_addr >= BASE_ADDR) && (word_idx < 32'(DEPTH_WORDS));
    access_err = ~in_range | (cur_size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    access_err = access_err
               | ((cur_size == SIZE_HALF) & cur_addr[0])
               | ((cur_size == SIZE_WORD) & (cur_addr[1:0] != 2'b00));
`endif
  end

  dmem_lane_align u_lane_align (
    .size_i     (cur_size),
    .signed_i   (cur_sgn),
    .lane_i     (cur_addr[1:0]),
    .mem_word_i (mem[mem_idx]),
    .wdata_i    (cur_wdata),
    .rdata_o    (lane_rdata),
    .wmask_o    (lane_wmask),
    .wdata_o    (lane_wdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          addr_d  = req_addr;
          size_d  = req_size;
          sgn_d   = req_signed;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) enter_resp = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      state_d = ST_RESP;
      err_d   = access_err;
      rdata_d = (cur_rw | access_err) ? '0 : lane_rdata;
    end
    mem_we = enter_resp & cur_rw & ~access_err;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared by reset; reset only suppresses the write strobe.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_wmask[i]) mem[mem_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus stall and
// reset-in-flight sequences, responses checked through a scoreboard queue.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int WAIT_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clock = ~clock;

  dmem_responder #(
    .DEPTH_WORDS (262144),
    .BASE_ADDR   (32'h0100_0000),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    string       name;
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rw, input logic [31:0] addr,
                              input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.rw = rw; v.addr = addr; v.size = size; v.sgn = sgn;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic pop_and_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard: got empty queue expected entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, " rdata"}, rsp_rdata, e.rdata);
      chk({name, " err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    chk({name, " accept"}, 32'(req_ready), 32'd1);
    @(posedge clock);
  endtask

  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    do begin @(negedge clock); lat++; end while (!rsp_valid && lat < 30);
    chk({name, " latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
  endtask

  task automatic drive(input vec_t v);
    req_valid = 1'b1; req_rw = v.rw; req_addr = v.addr; req_size = v.size;
    req_signed = v.sgn; req_wdata = v.wdata;
  endtask

  task automatic issue(input vec_t v);
    int lat;
    @(negedge clock);
    drive(v);
    sb.push_back('{v.exp_rdata, v.exp_err});
    wait_accept(v.name);
    #1 req_valid = 1'b0;
    wait_rsp(v.name, lat);
    pop_and_check(v.name);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    int   stray;
    vec_t v;
    logic [31:0] mis_word_exp, mis_half_exp;
    logic        mis_err_exp;

`ifdef DMEM_MISALIGN_TRAP_EN
    mis_word_exp = 32'h0; mis_half_exp = 32'h0; mis_err_exp = 1'b1;
`else
    mis_word_exp = 32'hDEAD55EF; mis_half_exp = 32'h000055EF; mis_err_exp = 1'b0;
`endif

    vecs.push_back(mk("wr_word",      1, 32'h0100_0000, SIZE_WORD, 0, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk("rd_word",      0, 32'h0100_0000, SIZE_WORD, 0, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("rd_byte_s",    0, 32'h0100_0003, SIZE_BYTE, 1, 32'h0, 32'hFFFFFFDE, 0));
    vecs.push_back(mk("rd_byte_u",    0, 32'h0100_0003, SIZE_BYTE, 0, 32'h0, 32'h000000DE, 0));
    vecs.push_back(mk("rd_half_s",    0, 32'h0100_0000, SIZE_HALF, 1, 32'h0, 32'hFFFFBEEF, 0));
    vecs.push_back(mk("wr_byte",      1, 32'h0100_0001, SIZE_BYTE, 0, 32'hAAAAAA55, 32'h0, 0));
    vecs.push_back(mk("rd_after_byte",0, 32'h0100_0000, SIZE_WORD, 1, 32'h0, 32'hDEAD55EF, 0));
    vecs.push_back(mk("rd_byte_pos_s",0, 32'h0100_0001, SIZE_BYTE, 1, 32'h0, 32'h00000055, 0));
    vecs.push_back(mk("rd_half_hi_u", 0, 32'h0100_0002, SIZE_HALF, 0, 32'h0, 32'h0000DEAD, 0));
    vecs.push_back(mk("rd_below_base",0, 32'h00FF_FFFC, SIZE_WORD, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk("rd_word_mis",  0, 32'h0100_0002, SIZE_WORD, 0, 32'h0, mis_word_exp, mis_err_exp));
    vecs.push_back(mk("rd_half_mis",  0, 32'h0100_0001, SIZE_HALF, 1, 32'h0, mis_half_exp, mis_err_exp));
    vecs.push_back(mk("wr_size3",     1, 32'h0100_0000, 2'd3,      0, 32'h0, 32'h0, 1));
    vecs.push_back(mk("rd_size3",     0, 32'h0100_0000, 2'd3,      0, 32'h0, 32'h0, 1));
    vecs.push_back(mk("rd_not_dropped",0,32'h0100_0000, SIZE_WORD, 0, 32'h0, 32'hDEAD55EF, 0));
    vecs.push_back(mk("wr_word1",     1, 32'h0100_0004, SIZE_WORD, 0, 32'h0000_0000, 32'h0, 0));
    vecs.push_back(mk("wr_half_hi",   1, 32'h0100_0006, SIZE_HALF, 0, 32'hFFFF1234, 32'h0, 0));
    vecs.push_back(mk("rd_word1",     0, 32'h0100_0004, SIZE_WORD, 0, 32'h0, 32'h12340000, 0));
    vecs.push_back(mk("wr_last",      1, 32'h010F_FFFC, SIZE_WORD, 0, 32'hCAFEF00D, 32'h0, 0));
    vecs.push_back(mk("rd_last",      0, 32'h010F_FFFC, SIZE_WORD, 0, 32'h0, 32'hCAFEF00D, 0));
    vecs.push_back(mk("rd_past_end",  0, 32'h0110_0000, SIZE_WORD, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk("wr_past_end",  1, 32'h0110_0000, SIZE_WORD, 0, 32'h12345678, 32'h0, 1));

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1 chk("ready after reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

    // Response stall with a competing request held on the bus
    @(negedge clock);
    v = mk("stall", 0, 32'h0100_0000, SIZE_WORD, 0, 32'h0, 32'hDEAD55EF, 0);
    drive(v);
    sb.push_back('{v.exp_rdata, v.exp_err});
    wait_accept("stall");
    #1 begin req_rw = 1'b1; req_wdata = 32'h0; end
    wait_rsp("stall", lat);
    for (int c = 0; c < 5; c++) begin
      chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall rdata", rsp_rdata, 32'hDEAD55EF);
      chk("stall req_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
    end
    pop_and_check("stall");
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 begin rsp_ready = 1'b0; req_valid = 1'b0; end
    stray = 0;
    repeat (6) begin @(negedge clock); if (rsp_valid) stray++; end
    chk("stall no second rsp", 32'(stray), 32'd0);
    issue(mk("stall_wr_dropped", 0, 32'h0100_0000, SIZE_WORD, 0, 32'h0, 32'hDEAD55EF, 0));

    // Reset while a write waits
    @(negedge clock);
    drive(mk("rst_wr", 1, 32'h0100_0000, SIZE_WORD, 0, 32'h11111111, 32'h0, 0));
    wait_accept("rst_wr");
    #1 req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1 begin
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 chk("rst ready again", 32'(req_ready), 32'd1);
    stray = 0;
    repeat (4) begin @(negedge clock); if (rsp_valid) stray++; end
    chk("rst no rsp", 32'(stray), 32'd0);
    issue(mk("rst_word_kept", 0, 32'h0100_0000, SIZE_WORD, 0, 32'h0, 32'hDEAD55EF, 0));

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
